router_pkt_tx: RTL and testbench

//  Packet transmitter for the input side of the 1x3 router. Takes a command (dest addr, payload length)
//  and a byte stream, buffers the full payload, then drives the router input as header, payload, parity.

---
 rtl/router_pkt_tx_pkg.sv | 21 ++
 rtl/router_pkt_tx_buf.sv | 26 ++
 rtl/router_pkt_tx.sv | 155 +++++++++++++++
 tb/tb_router_pkt_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkt_tx_pkg.sv
// Shared types and helpers for the router packet transmitter.
package router_pkt_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_HDR  = 3'd2,
    ST_PAY  = 3'd3,
    ST_PAR  = 3'd4,
    ST_GAP  = 3'd5
  } state_t;

  // Address value the router has no output FIFO for.
  localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

  // Router header byte: length in the upper six bits, destination in the lower two.
  function automatic logic [7:0] build_hdr(input logic [5:0] len, input logic [1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_tx_buf.sv
// Payload buffer: synchronous write, asynchronous read so the FSM can load
// the next byte into the output register on the same edge it is addressed.
module router_pkt_tx_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  // Store a payload byte on each accepted write beat.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding the router input: buffers a full payload, then
// sends header, payload and parity while honouring the router's busy.
module router_pkt_tx
  import router_pkt_tx_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int BUF_DEPTH  = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
  input  logic       cmd_bad_parity,
  output logic       cmd_err,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       busy,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_done,
  output logic       tx_active
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t        r_state;
  logic [1:0]    r_addr;
  logic [5:0]    r_len;
  logic          r_bad;
  logic [7:0]    r_parity;
  logic [5:0]    r_wcnt;
  logic [5:0]    r_rcnt;
  logic [GW-1:0] r_gcnt;
  logic [7:0]    r_pkt_data;
  logic          r_pkt_valid;
  logic          r_cmd_err;
  logic          r_pkt_done;

  logic          w_we;
  logic [7:0]    w_rdata;

  assign w_we = (r_state == ST_FILL) && wr_valid;

  router_pkt_tx_buf #(
    .DEPTH (BUF_DEPTH),
    .AW    (AW)
  ) u_buf (
    .clock   (clock),
    .i_we    (w_we),
    .i_waddr (AW'(r_wcnt)),
    .i_wdata (wr_data),
    .i_raddr (AW'(r_rcnt)),
    .o_rdata (w_rdata)
  );

  // Main sequencer: command intake, payload fill, then header/payload/parity
  // on the router bus; nothing on the bus advances while busy is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= 2'd0;
      r_len       <= 6'd0;
      r_bad       <= 1'b0;
      r_parity    <= 8'd0;
      r_wcnt      <= 6'd0;
      r_rcnt      <= 6'd0;
      r_gcnt      <= '0;
      r_pkt_data  <= 8'd0;
      r_pkt_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_pkt_done  <= 1'b0;
    end else begin
      r_cmd_err  <= 1'b0;
      r_pkt_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if ((cmd_len == 6'd0) || (cmd_addr == ADDR_ILLEGAL)) begin
              r_cmd_err <= 1'b1;
            end else begin
              r_addr   <= cmd_addr;
              r_len    <= cmd_len;
              r_bad    <= cmd_bad_parity;
              r_parity <= build_hdr(cmd_len, cmd_addr);
              r_wcnt   <= 6'd0;
              r_state  <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (wr_valid) begin
            r_parity <= r_parity ^ wr_data;
            r_wcnt   <= r_wcnt + 6'd1;
            if (r_wcnt == (r_len - 6'd1)) begin
              r_pkt_data  <= build_hdr(r_len, r_addr);
              r_pkt_valid <= 1'b1;
              r_rcnt      <= 6'd0;
              r_state     <= ST_HDR;
            end
          end
        end
        ST_HDR: begin
          // Read address is still zero here, so w_rdata is the first payload byte.
          if (!busy) begin
            r_pkt_data <= w_rdata;
            r_rcnt     <= 6'd1;
            r_state    <= ST_PAY;
          end
        end
        ST_PAY: begin
          if (!busy) begin
            if (r_rcnt == r_len) begin
              r_pkt_data  <= r_parity ^ {7'd0, r_bad};
              r_pkt_valid <= 1'b0;
              r_state     <= ST_PAR;
            end else begin
              r_pkt_data <= w_rdata;
              r_rcnt     <= r_rcnt + 6'd1;
            end
          end
        end
        ST_PAR: begin
          if (!busy) begin
            r_pkt_done <= 1'b1;
            r_pkt_data <= 8'd0;
            r_gcnt     <= '0;
            r_state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (r_gcnt == GAP_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign wr_ready  = (r_state == ST_FILL);
  assign tx_active = (r_state == ST_HDR) || (r_state == ST_PAY) || (r_state == ST_PAR);
  assign pkt_data  = r_pkt_data;
  assign pkt_valid = r_pkt_valid;
  assign cmd_err   = r_cmd_err;
  assign pkt_done  = r_pkt_done;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: expected bus bytes are queued when a
// packet is issued and compared as each byte transfers to the router.
module tb_router_pkt_tx;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       cmd_bad_parity;
  logic       cmd_err;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       busy;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_done;
  logic       tx_active;

  router_pkt_tx #(
    .GAP_CYCLES (GAP),
    .BUF_DEPTH  (64)
  ) dut (
    .clock          (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .cmd_bad_parity (cmd_bad_parity),
    .cmd_err        (cmd_err),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .busy           (busy),
    .pkt_data       (pkt_data),
    .pkt_valid      (pkt_valid),
    .pkt_done       (pkt_done),
    .tx_active      (tx_active)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       last;
    int         occ;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] pay [64];
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         par_cyc = 0;
  int         last_gap = 0;
  int         vcnt = 0;
  logic       done_due = 1'b0;
  logic       prev_hold = 1'b0;
  logic       prev_v = 1'b0;
  logic [8:0] prev_bus = 9'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Bus monitor: pops the scoreboard on every transfer edge and checks hold,
  // done pulse, bus occupancy and inter-packet spacing.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      prev_hold = 1'b0;
      done_due  = 1'b0;
      vcnt      = 0;
      prev_v    = 1'b0;
    end else begin
      if (done_due || pkt_done) check("pkt_done", {31'd0, pkt_done}, {31'd0, done_due});
      done_due = 1'b0;
      if (prev_hold) check("hold", {23'd0, pkt_valid, pkt_data}, {23'd0, prev_bus});
      if (pkt_valid) vcnt++;
      if (pkt_valid && !prev_v) last_gap = cyc - par_cyc;
      prev_v = pkt_valid;
      if (!busy && tx_active) begin
        if (sb_q.size() == 0) begin
          check("sb_nonempty", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("pkt_valid", {31'd0, pkt_valid}, {31'd0, e.v});
          check("pkt_data", {24'd0, pkt_data}, {24'd0, e.d});
          $display("xfer cyc=%0d valid=%0d data=0x%02h", cyc, pkt_valid, pkt_data);
          if (e.last) begin
            done_due = 1'b1;
            par_cyc  = cyc;
            if (e.occ >= 0) check("occupancy", 32'(vcnt), 32'(e.occ));
            vcnt = 0;
          end
        end
      end
      prev_hold = busy && tx_active;
      prev_bus  = {pkt_valid, pkt_data};
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!cmd_ready && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cmd_ready) check("ready_timeout", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Issue one packet from pay[], queue its expected bus bytes, fill the buffer,
  // then optionally stall the router for hold_cyc edges after the header transfers.
  task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input logic bad,
                          input int hold_cyc, input bit chk_occ);
    logic [7:0] par;
    wait_ready();
    par = {l, a};
    sb_q.push_back('{v: 1'b1, d: {l, a}, last: 1'b0, occ: -1});
    for (int i = 0; i < int'(l); i++) begin
      sb_q.push_back('{v: 1'b1, d: pay[i], last: 1'b0, occ: -1});
      par = par ^ pay[i];
    end
    sb_q.push_back('{v: 1'b0, d: par ^ {7'd0, bad}, last: 1'b1, occ: chk_occ ? int'(l) + 1 : -1});
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_bad_parity = bad;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < int'(l); i++) begin
      wr_valid = 1'b1;
      wr_data  = pay[i];
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    check("hdr_latency", {31'd0, pkt_valid}, 32'd1);
    $display("cmd addr=%0d len=%0d bad=%0d issued", a, l, bad);
    if (hold_cyc > 0) begin
      @(posedge clk); #1;
      busy = 1'b1;
      repeat (hold_cyc) @(posedge clk);
      #1 busy = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb_q.size() != 0 || !cmd_ready) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) check("idle_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = 2'd0; cmd_len = 6'd0;
    cmd_bad_parity = 1'b0; wr_data = 8'd0; wr_valid = 1'b0; busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_pkt_data", {24'd0, pkt_data}, 32'd0);
    check("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_tx_active", {31'd0, tx_active}, 32'd0);
    check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    check("rst_pkt_done", {31'd0, pkt_done}, 32'd0);

    // Packet 1: addr0 len14, bytes 0x01..0x0E, no stall.
    for (int i = 0; i < 14; i++) pay[i] = 8'(i + 1);
    send_pkt(2'd0, 6'd14, 1'b0, 0, 1'b1);
    wait_idle();

    // Packet 2: same, router busy for three edges after the header.
    send_pkt(2'd0, 6'd14, 1'b0, 3, 1'b0);
    wait_idle();

    // Packet 3: single-byte payload to FIFO 2.
    pay[0] = 8'hA5;
    send_pkt(2'd2, 6'd1, 1'b0, 0, 1'b1);
    wait_idle();

    // Illegal commands are dropped with an error pulse.
    cmd_valid = 1'b1; cmd_len = 6'd0; cmd_addr = 2'd1;
    @(posedge clk); #1;
    check("err_len0", {31'd0, cmd_err}, 32'd1);
    check("ready_len0", {31'd0, cmd_ready}, 32'd1);
    cmd_len = 6'd5; cmd_addr = 2'd3;
    @(posedge clk); #1;
    check("err_addr3", {31'd0, cmd_err}, 32'd1);
    check("ready_addr3", {31'd0, cmd_ready}, 32'd1);
    check("valid_illegal", {31'd0, pkt_valid}, 32'd0);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("err_clear", {31'd0, cmd_err}, 32'd0);
    check("stay_idle", {31'd0, wr_ready}, 32'd0);

    // Packet 5: forced bad parity.
    for (int i = 0; i < 14; i++) pay[i] = 8'(i + 1);
    send_pkt(2'd0, 6'd14, 1'b1, 0, 1'b1);
    wait_idle();

    // Reset in the middle of the payload abandons the packet.
    send_pkt(2'd1, 6'd14, 1'b0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", {31'd0, pkt_valid}, 32'd0);
    check("mid_rst_data", {24'd0, pkt_data}, 32'd0);
    check("mid_rst_active", {31'd0, tx_active}, 32'd0);
    @(posedge clk); #1;
    sb_q.delete();
    reset = 1'b0;

    // Back-to-back single-byte packets: spacing after the parity transfer.
    pay[0] = 8'hA5;
    send_pkt(2'd2, 6'd1, 1'b0, 0, 1'b1);
    send_pkt(2'd2, 6'd1, 1'b0, 0, 1'b1);
    @(negedge clk); #1;
    check("gap_min", {31'd0, last_gap >= GAP + 2}, 32'd1);
    wait_idle();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
